acc_cpu_param: RTL and testbench
================================

Name: acc_cpu_param

Overview:
- Parametrised successor to the team's 8-bit accumulator CPU core. Adds configurable data, PC and operand widths and a small register file.
- Adds ZERO/CARRY flags and conditional branches.
- Adds a fetch handshake (instr_valid) so instruction memory may insert wait states.
- Adds run gating and halt/resume control. Sits between instr_mem (or a slower ROM) and the system bench/top level.

Parameters:
DATA_W, 8, accumulator, register and immediate data width (>=4)
PC_W, 8, program counter width; instruction address space 2^PC_W
OPER_W, 4, operand field width; instruction width INSTR_W = 4 + OPER_W
NREGS, 4, register-file entries (power of 2, <= 2^OPER_W); REG_AW = log2(NREGS)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
run  input  1  1 = fetch permitted; 0 = hold in FETCH (no new fetch accepted)
resume  input  1  single-cycle pulse; leave HALTED
instr  input  INSTR_W  {opcode[3:0], operand[OPER_W-1:0]} addressed by pc
instr_valid  input  1  instr is valid for the current pc this cycle
pc  output  PC_W  fetch address
acc  output  DATA_W  accumulator
zero  output  1  Z flag
carry  output  1  C flag
halted  output  1  1 while in HALTED
retired  output  1  one-cycle pulse per executed instruction

Behaviour:
- Reset (reset_n=0, async): pc=0, acc=0, zero=0, carry=0, halted=0, retired=0, IR=0, all registers=0, state=FETCH. Reset dominates all inputs in every state.
- States: FETCH, EXEC, HALTED.
- FETCH:
  - If run=1 and instr_valid=1: IR<=instr, go EXEC.
  - Otherwise stay; pc held.
- EXEC:
  - Execute IR; retired=1 for this cycle only.
  - pc <= next pc; go FETCH, or HALTED for HALT.
  - With zero-wait memory, one instruction per 2 cycles.
- HALTED:
  - halted=1; pc, acc, flags and registers frozen.
  - resume=1: go FETCH next edge, halted=0 from that edge.
  - run and instr_valid ignored.
- Operand handling: imm = operand zero-extended to DATA_W. Register index = operand[REG_AW-1:0]. Jump target = operand zero-extended to PC_W.
- Opcodes (Z = result==0 whenever acc is written; C unchanged unless listed):
  - 0 NOP
  - 1 LDI: acc<=imm
  - 2 ADDI: acc<=acc+imm; C=carry-out
  - 3 SUBI: acc<=acc-imm; C=borrow (acc<imm)
  - 4 LD: acc<=r[idx]
  - 5 ST: r[idx]<=acc; flags unchanged
  - 6 ADD: acc<=acc+r[idx]; C=carry-out
  - 7 AND
  - 8 OR
  - 9 XOR
  - A SHL: C=acc msb
  - B SHR: C=acc lsb; logical shift
  - C JMP
  - D JZ: taken if Z=1
  - E JC: taken if C=1
  - F HALT
- Branches and jumps use the flag value at the start of EXEC and change no flags.
- Arithmetic is modulo 2^DATA_W.
- Next pc = target if taken, else pc+1 modulo 2^PC_W; 0x..FF wraps to 0.
- HALT also advances pc to pc+1, so resume continues after the HALT.
- resume outside HALTED has no effect.
- run=0 during EXEC does not abort that instruction.
- instr_valid in EXEC is ignored.
- Reset asserted mid-EXEC: the instruction does not retire and no register write occurs.

Test Plan:
- Program 0x15,0x23,0x51,0x38,0xD6,0x1F,0xF0, zero-wait, run=1 → acc 05, 08, 08, 00 (Z=1, C=0). JZ is taken to pc=6, so 0x1F never executes. HALT leaves halted=1 with pc=7. r1=08. retired pulses 6 times, 2 cycles apart.
- LDI 0, SUBI 1, ADDI 1 → acc=FF with C=1, Z=0; then acc=00 with C=1, Z=1. SHL on acc=0x80 → acc=00, C=1, Z=1.
- Hold instr_valid=0 for 3 cycles in FETCH → pc unchanged, retired stays 0, state stays FETCH. run=0 with instr_valid=1 gives the same result. Execution resumes on the first cycle with both high.
- NOPs from pc=0xFE → pc goes FE, FF, 00. JC not taken with C=0 → pc+1.
- In HALTED at pc=7, pulse resume → halted=0 next cycle and fetch at pc=7 (the address after the HALT). Pulse resume while running → no effect.
- Drive reset_n low asynchronously mid-EXEC of ST → outputs 0 immediately without a clock edge, the register is not written, and restart is at pc=0.

Source files
------------

// File: rtl/acc_cpu_param.sv
// Parametrised accumulator CPU: FETCH/EXEC/HALTED sequencer, small register file,
// zero/carry flags, conditional branches and an instruction-valid fetch handshake.
module acc_cpu_param #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int OPER_W = 4,
  parameter int NREGS  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              resume,
  input  logic [OPER_W+3:0] instr,
  input  logic              instr_valid,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] acc,
  output logic              zero,
  output logic              carry,
  output logic              halted,
  output logic              retired
);

  localparam int INSTR_W = 4 + OPER_W;
  localparam int REG_AW  = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC   = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADDI = 4'h2,
    OP_SUBI = 4'h3,
    OP_LD   = 4'h4,
    OP_ST   = 4'h5,
    OP_ADD  = 4'h6,
    OP_AND  = 4'h7,
    OP_OR   = 4'h8,
    OP_XOR  = 4'h9,
    OP_SHL  = 4'hA,
    OP_SHR  = 4'hB,
    OP_JMP  = 4'hC,
    OP_JZ   = 4'hD,
    OP_JC   = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [DATA_W-1:0]    acc_q, acc_d;
  logic                 zero_q, zero_d;
  logic                 carry_q, carry_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]    regs_q [NREGS];

  opcode_e              opcode;
  logic [OPER_W-1:0]    operand;
  logic [DATA_W-1:0]    imm;
  logic [REG_AW-1:0]    reg_idx;
  logic [DATA_W-1:0]    reg_rdata;
  logic [PC_W-1:0]      target;
  logic [PC_W-1:0]      pc_inc;
  logic [DATA_W:0]      add_imm;
  logic [DATA_W:0]      sub_imm;
  logic [DATA_W:0]      add_reg;
  logic [DATA_W-1:0]    result;
  logic                 acc_wr;
  logic                 reg_we;

  assign opcode    = opcode_e'(ir_q[INSTR_W-1 -: 4]);
  assign operand   = ir_q[OPER_W-1:0];
  assign imm       = DATA_W'(operand);
  assign reg_idx   = operand[REG_AW-1:0];
  assign reg_rdata = regs_q[reg_idx];
  assign target    = PC_W'(operand);
  assign pc_inc    = pc_q + PC_W'(1);

  // The extra top bit of each sum is the carry-out, or the borrow for the subtract.
  assign add_imm = {1'b0, acc_q} + {1'b0, imm};
  assign sub_imm = {1'b0, acc_q} - {1'b0, imm};
  assign add_reg = {1'b0, acc_q} + {1'b0, reg_rdata};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ir_d    = ir_q;
    reg_we  = 1'b0;
    acc_wr  = 1'b0;
    result  = acc_q;

    case (state_q)
      S_FETCH: begin
        if (run && instr_valid) begin
          ir_d    = instr;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        // Branch conditions see the flags as they were before this instruction.
        case (opcode)
          OP_NOP: ;
          OP_LDI: begin
            acc_wr = 1'b1;
            result = imm;
          end
          OP_ADDI: begin
            acc_wr  = 1'b1;
            result  = add_imm[DATA_W-1:0];
            carry_d = add_imm[DATA_W];
          end
          OP_SUBI: begin
            acc_wr  = 1'b1;
            result  = sub_imm[DATA_W-1:0];
            carry_d = sub_imm[DATA_W];
          end
          OP_LD: begin
            acc_wr = 1'b1;
            result = reg_rdata;
          end
          OP_ST:  reg_we = 1'b1;
          OP_ADD: begin
            acc_wr  = 1'b1;
            result  = add_reg[DATA_W-1:0];
            carry_d = add_reg[DATA_W];
          end
          // Logic ops take their second operand from the register file, like ADD.
          OP_AND: begin
            acc_wr = 1'b1;
            result = acc_q & reg_rdata;
          end
          OP_OR: begin
            acc_wr = 1'b1;
            result = acc_q | reg_rdata;
          end
          OP_XOR: begin
            acc_wr = 1'b1;
            result = acc_q ^ reg_rdata;
          end
          OP_SHL: begin
            acc_wr  = 1'b1;
            result  = {acc_q[DATA_W-2:0], 1'b0};
            carry_d = acc_q[DATA_W-1];
          end
          OP_SHR: begin
            acc_wr  = 1'b1;
            result  = {1'b0, acc_q[DATA_W-1:1]};
            carry_d = acc_q[0];
          end
          OP_JMP: pc_d = target;
          OP_JZ: begin
            if (zero_q) pc_d = target;
          end
          OP_JC: begin
            if (carry_q) pc_d = target;
          end
          OP_HALT: state_d = S_HALTED;
          default: ;
        endcase

        if (acc_wr) begin
          acc_d  = result;
          zero_d = (result == '0);
        end
      end

      S_HALTED: begin
        if (resume) state_d = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      acc_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ir_q    <= ir_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[reg_idx] <= acc_q;
    end
  end

  // Retire is decoded from state so an async reset mid-EXEC drops it at once.
  assign pc      = pc_q;
  assign acc     = acc_q;
  assign zero    = zero_q;
  assign carry   = carry_q;
  assign halted  = (state_q == S_HALTED);
  assign retired = (state_q == S_EXEC);

endmodule

// File: tb/tb_acc_cpu_param.sv
// Scoreboard bench for acc_cpu_param: an instruction-level model fills an expected
// queue per program, and a monitor pops one entry per retired instruction.
module tb_acc_cpu_param;

  localparam int NREGS = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       run;
  logic       resume;
  logic [7:0] instr;
  logic       instr_valid;
  logic [7:0] pc;
  logic [7:0] acc;
  logic       zero;
  logic       carry;
  logic       halted;
  logic       retired;

  logic [7:0] mem [256];

  typedef struct {
    int pc;
    int acc;
    int z;
    int c;
    int halted;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp    = 0;
  int n_fail   = 0;
  int n_retire = 0;
  bit mon_en   = 1'b1;
  bit rand_mode = 1'b0;

  int m_pc, m_acc, m_z, m_c, m_halted;
  int m_regs [NREGS];

  acc_cpu_param #(
    .DATA_W(8),
    .PC_W  (8),
    .OPER_W(4),
    .NREGS (NREGS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .resume     (resume),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .acc        (acc),
    .zero       (zero),
    .carry      (carry),
    .halted     (halted),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // Instruction memory answers the current fetch address combinationally.
  assign instr = mem[pc];

  task automatic checkOutput(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_acc = 0; m_z = 0; m_c = 0; m_halted = 0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
  endtask

  // Executes one instruction at m_pc using plain integer arithmetic.
  task automatic model_step();
    int op, opd, idx, r, npc, wr;
    logic [7:0] word;
    exp_t e;
    word = mem[m_pc];
    op   = int'(word[7:4]);
    opd  = int'(word[3:0]);
    idx  = opd % NREGS;
    r    = m_regs[idx];
    npc  = (m_pc + 1) % 256;
    wr   = 1;
    case (op)
      0:  wr = 0;
      1:  m_acc = opd;
      2:  begin m_c = (m_acc + opd > 255) ? 1 : 0; m_acc = (m_acc + opd) % 256; end
      3:  begin m_c = (m_acc < opd) ? 1 : 0; m_acc = (m_acc - opd + 256) % 256; end
      4:  m_acc = r;
      5:  begin m_regs[idx] = m_acc; wr = 0; end
      6:  begin m_c = (m_acc + r > 255) ? 1 : 0; m_acc = (m_acc + r) % 256; end
      7:  m_acc = m_acc & r;
      8:  m_acc = m_acc | r;
      9:  m_acc = m_acc ^ r;
      10: begin m_c = m_acc / 128; m_acc = (m_acc * 2) % 256; end
      11: begin m_c = m_acc % 2; m_acc = m_acc / 2; end
      12: begin npc = opd; wr = 0; end
      13: begin if (m_z == 1) npc = opd; wr = 0; end
      14: begin if (m_c == 1) npc = opd; wr = 0; end
      default: begin m_halted = 1; wr = 0; end
    endcase
    if (wr == 1) m_z = (m_acc == 0) ? 1 : 0;
    m_pc = npc;
    e.pc = m_pc; e.acc = m_acc; e.z = m_z; e.c = m_c; e.halted = m_halted;
    exp_q.push_back(e);
  endtask

  task automatic model_run(input int max_steps);
    int n = 0;
    while (m_halted == 0 && n < max_steps) begin
      model_step();
      n++;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset_n = 1'b0;
    run = 1'b0;
    instr_valid = 1'b0;
    resume = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    n_retire = 0;
    reset_n = 1'b1;
  endtask

  task automatic wait_halt(input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (halted) break;
      if (rand_mode) begin
        instr_valid = ($urandom_range(0, 3) != 0);
        run = ($urandom_range(0, 4) != 0);
      end
    end
    checkOutput("reached_halt", halted, 1);
    checkOutput("queue_drained", exp_q.size(), 0);
  endtask

  // Loads a program, precomputes its expected retirements and lets the DUT run.
  task automatic applyStimulus(input logic [7:0] prog [], input int max_steps);
    clear_mem();
    foreach (prog[i]) mem[i] = prog[i];
    resetDut();
    model_reset();
    model_run(max_steps);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && reset_n && retired) begin
        @(posedge clk);
        #1;
        n_retire++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_retire_pc", pc, 256);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pc", pc, e.pc);
          checkOutput("acc", acc, e.acc);
          checkOutput("zero", zero, e.z);
          checkOutput("carry", carry, e.c);
          checkOutput("halted", halted, e.halted);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] prog [];
    int cyc;
    int found;
    logic [3:0] op4, opd4;

    reset_n = 1'b1;
    run = 1'b0;
    resume = 1'b0;
    instr_valid = 1'b0;
    clear_mem();
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_pc", pc, 0);
    checkOutput("rst_acc", acc, 0);
    checkOutput("rst_zero", zero, 0);
    checkOutput("rst_carry", carry, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_retired", retired, 0);

    $display("[TB] program: LDI/ADDI/ST/SUBI/JZ/HALT");
    prog = '{8'h15, 8'h23, 8'h51, 8'h38, 8'hD6, 8'h1F, 8'hF0, 8'h41, 8'hF0};
    applyStimulus(prog, 64);
    run = 1'b1;
    instr_valid = 1'b1;
    wait_halt(100, cyc);
    checkOutput("p1_cycles", cyc, 12);
    checkOutput("p1_retires", n_retire, 6);
    checkOutput("p1_pc", pc, 7);
    checkOutput("p1_acc", acc, 0);
    checkOutput("p1_zero", zero, 1);
    checkOutput("p1_carry", carry, 0);
    repeat (4) begin
      @(negedge clk);
      checkOutput("frozen_pc", pc, 7);
      checkOutput("frozen_halted", halted, 1);
      checkOutput("frozen_retired", retired, 0);
    end

    $display("[TB] resume after HALT");
    resume = 1'b1;
    m_halted = 0;
    model_run(8);
    @(posedge clk);
    #1;
    resume = 1'b0;
    checkOutput("resume_halted", halted, 0);
    checkOutput("resume_pc", pc, 7);
    @(negedge clk);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    wait_halt(100, cyc);
    checkOutput("resume_acc", acc, 8);
    checkOutput("resume_final_pc", pc, 9);

    $display("[TB] arithmetic flags with fetch wait states");
    prog = '{8'h10, 8'h31, 8'h21, 8'h18, 8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hF0};
    applyStimulus(prog, 64);
    run = 1'b1;
    instr_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("novalid_pc", pc, 0);
      checkOutput("novalid_retired", retired, 0);
    end
    run = 1'b0;
    instr_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("norun_pc", pc, 0);
      checkOutput("norun_retired", retired, 0);
    end
    run = 1'b1;
    @(negedge clk);
    checkOutput("first_accept_retired", retired, 1);
    wait_halt(100, cyc);
    checkOutput("p2_acc", acc, 0);
    checkOutput("p2_carry", carry, 1);
    checkOutput("p2_zero", zero, 1);
    checkOutput("p2_pc", pc, 10);

    $display("[TB] pc wrap through FE, FF, 00");
    prog = '{8'hE5};
    applyStimulus(prog, 258);
    run = 1'b1;
    instr_valid = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 1200) begin
      @(negedge clk);
      cyc++;
    end
    run = 1'b0;
    checkOutput("wrap_drained", exp_q.size(), 0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("wrap_idle_pc", pc, 2);
      checkOutput("wrap_idle_retired", retired, 0);
    end

    $display("[TB] random programs with random run/instr_valid");
    for (int t = 0; t < 8; t++) begin
      prog = new[16];
      for (int a = 0; a < 15; a++) begin
        op4  = 4'($urandom_range(0, 14));
        opd4 = (op4 >= 4'hC) ? 4'($urandom_range(a + 1, 15)) : 4'($urandom_range(0, 15));
        prog[a] = {op4, opd4};
      end
      prog[15] = 8'hF0;
      applyStimulus(prog, 64);
      rand_mode = 1'b1;
      wait_halt(400, cyc);
      rand_mode = 1'b0;
    end

    $display("[TB] async reset during ST execute");
    mon_en = 1'b0;
    prog = '{8'h19, 8'h52, 8'h00};
    applyStimulus(prog, 0);
    run = 1'b1;
    instr_valid = 1'b1;
    found = 0;
    cyc = 0;
    while (found == 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (retired && pc == 8'd1) found = 1;
    end
    checkOutput("st_exec_reached", found, 1);
    checkOutput("acc_before_reset", acc, 9);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("async_acc", acc, 0);
    checkOutput("async_pc", pc, 0);
    checkOutput("async_retired", retired, 0);
    checkOutput("async_halted", halted, 0);
    repeat (2) @(negedge clk);
    mem[0] = 8'h42;
    mem[1] = 8'hF0;
    model_reset();
    model_run(8);
    mon_en = 1'b1;
    reset_n = 1'b1;
    wait_halt(50, cyc);
    checkOutput("restart_acc", acc, 0);
    checkOutput("restart_zero", zero, 1);
    checkOutput("restart_pc", pc, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
